div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_if.sv | 22 ++
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// start is level-held by the master until it sees ready; ready is held until start drops.
interface div_if;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle 32/32 restoring divider: one quotient bit per cycle, signed via magnitudes
// plus a sign fix-up, result {remainder, quotient} held in END until start drops.
module div_ctrl (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        is_signed_q, is_signed_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        op_neg1, op_neg2;
  logic [31:0] mag1, mag2;
  logic [32:0] trial;
  logic        q_bit;
  logic [64:0] step_val;
  logic [31:0] quo_fix, rem_fix;

  // Datapath: operand magnitudes, one shift-subtract step, and the final sign fix-up.
  always_comb begin
    op_neg1  = bus.signed_div & bus.opdata1[31];
    op_neg2  = bus.signed_div & bus.opdata2[31];
    mag1     = op_neg1 ? (32'd0 - bus.opdata1) : bus.opdata1;
    mag2     = op_neg2 ? (32'd0 - bus.opdata2) : bus.opdata2;
    trial    = work_q[63:31] - {1'b0, divisor_q};
    // Bit 64 extends the shifted remainder so the compare stays exact.
    q_bit    = work_q[64] | ~trial[32];
    step_val = q_bit ? {trial, work_q[30:0], 1'b1} : {work_q[63:0], 1'b0};
    quo_fix  = (is_signed_q & (neg1_q ^ neg2_q)) ? (32'd0 - step_val[31:0])  : step_val[31:0];
    rem_fix  = (is_signed_q & neg1_q)            ? (32'd0 - step_val[63:32]) : step_val[63:32];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    divisor_d   = divisor_q;
    is_signed_d = is_signed_q;
    neg1_d      = neg1_q;
    neg2_d      = neg2_q;
    ready_d     = 1'b0;
    result_d    = 64'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == 32'h0) begin
            state_d = S_BYZERO;
          end else begin
            state_d     = S_ON;
            cnt_d       = 6'd0;
            work_d      = {33'h0, mag1};
            divisor_d   = mag2;
            is_signed_d = bus.signed_div;
            neg1_d      = op_neg1;
            neg2_d      = op_neg2;
          end
        end
      end
      S_BYZERO: begin
        state_d = bus.annul ? S_IDLE : S_END;
        work_d  = 65'h0;
        cnt_d   = 6'd0;
      end
      S_ON: begin
        if (bus.annul) begin
          state_d = S_IDLE;
          work_d  = 65'h0;
          cnt_d   = 6'd0;
        end else begin
          work_d = step_val;
          cnt_d  = cnt_q + 6'd1;
          // The 32nd step lands directly in END with signs already fixed up.
          if (cnt_q == 6'd31) begin
            state_d = S_END;
            work_d  = {1'b0, rem_fix, quo_fix};
          end
        end
      end
      S_END: begin
        if (bus.start) begin
          ready_d  = 1'b1;
          result_d = work_q[63:0];
        end else begin
          state_d = S_IDLE;
          work_d  = 65'h0;
          cnt_d   = 6'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      work_q      <= 65'h0;
      divisor_q   <= 32'h0;
      is_signed_q <= 1'b0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      result_q    <= 64'h0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      divisor_q   <= divisor_d;
      is_signed_q <= is_signed_d;
      neg1_q      <= neg1_d;
      neg2_q      <= neg2_d;
      result_q    <= result_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.stall  = bus.start & ~ready_q & ~bus.annul;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed divides against literal results and latencies, plus a
// cycle-by-cycle reference of ready/result/stall built from the divide rules.
module tb_div_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  div_if      bus_if ();

  div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {remainder, quotient} from operand magnitudes; remainder follows the dividend's sign.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sd);
    longint ma, mb, q, r;
    logic   na, nb;
    if (b == 32'h0) return 64'h0;
    na = sd & a[31];
    nb = sd & b[31];
    ma = longint'({32'h0, a});
    mb = longint'({32'h0, b});
    if (na) ma = 64'sd4294967296 - ma;
    if (nb) mb = 64'sd4294967296 - mb;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- reference timeline ----------------
  logic        m_busy, m_ready;
  int          m_edges, m_target;
  logic [63:0] m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_edges <= 0;
    end else if (!m_busy) begin
      if (bus_if.start && !bus_if.annul) begin
        m_busy   <= 1'b1;
        m_edges  <= 1;
        m_target <= (bus_if.opdata2 == 32'h0) ? 3 : 34;
        m_exp    <= model_div(bus_if.opdata1, bus_if.opdata2, bus_if.signed_div);
      end
    end else if (m_ready) begin
      if (!bus_if.start) begin
        m_ready <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (bus_if.annul && m_edges < m_target - 1) begin
      // Cancel only counts before the result is committed (the edge before ready).
      m_busy <= 1'b0;
    end else begin
      m_edges <= m_edges + 1;
      if (m_edges + 1 == m_target) m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_ready", {63'h0, bus_if.ready}, {63'h0, m_ready});
      chk("cyc_result", bus_if.result, m_ready ? m_exp : 64'h0);
      chk("cyc_stall", {63'h0, bus_if.stall},
          {63'h0, bus_if.start & ~m_ready & ~bus_if.annul});
    end
  end

  // ---------------- driver ----------------
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sd,
                        output int lat, output logic [63:0] res);
    bit got;
    got = 1'b0;
    lat = 0;
    res = 64'h0;
    @(negedge clk); #1;
    bus_if.opdata1    = a;
    bus_if.opdata2    = b;
    bus_if.signed_div = sd;
    bus_if.start      = 1'b1;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      bus_if.opdata1    = $urandom;
      bus_if.opdata2    = $urandom;
      bus_if.signed_div = 1'($urandom_range(0, 1));
      if (bus_if.ready) begin
        got = 1'b1;
        res = bus_if.result;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_wait actual=no_ready required=ready_within_100");
    end
    @(negedge clk); #1;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- directed vectors ----------------
  localparam int NV = 9;
  logic [31:0] v_a   [NV] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd9,
                              32'd7, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] v_b   [NV] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd4,
                              32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 32'd3};
  logic        v_s   [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] v_exp [NV] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h0,
                              64'h00000000_80000000, 64'h00000001_00000002,
                              64'h00000001_FFFFFFFD, 64'hFFFFFFFE_00000002,
                              64'h00000000_FFFFFFFF, 64'h00000000_55555555};
  int          v_lat [NV] = '{34, 34, 3, 34, 34, 34, 34, 34, 34};

  logic [63:0] exp_q[$];

  initial begin
    int          lat;
    logic [63:0] res;
    int          seen;

    rst               = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.signed_div = 1'b0;
    bus_if.opdata1    = 32'h0;
    bus_if.opdata2    = 32'h0;
    bus_if.annul      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'h0, bus_if.ready}, 64'h0);
    chk("rst_result", bus_if.result, 64'h0);
    chk("rst_stall", {63'h0, bus_if.stall}, 64'h0);
    chk("rst_state", {62'h0, dbg_state}, 64'h0);
    @(negedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) chk($sformatf("model_%0d", i), model_div(v_a[i], v_b[i], v_s[i]), v_exp[i]);

    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(v_exp[i]);
      do_div(v_a[i], v_b[i], v_s[i], lat, res);
      chk($sformatf("lat_%0d", i), 64'(lat), 64'(v_lat[i]));
      chk($sformatf("res_%0d", i), res, exp_q.pop_front());
      chk($sformatf("idle_after_%0d", i), {62'h0, dbg_state}, 64'h0);
    end

    // Cancel on the 10th ON cycle with start still held.
    @(negedge clk); #1;
    bus_if.opdata1    = 32'hFFFFFFFF;
    bus_if.opdata2    = 32'd3;
    bus_if.signed_div = 1'b0;
    bus_if.start      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    bus_if.annul = 1'b1;
    #1;
    chk("annul_stall", {63'h0, bus_if.stall}, 64'h0);
    @(posedge clk); #1;
    chk("annul_idle", {62'h0, dbg_state}, 64'h0);
    @(negedge clk); #1;
    bus_if.annul = 1'b0;
    bus_if.start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_if.ready) seen++;
    end
    chk("annul_no_ready", 64'(seen), 64'h0);

    // Asynchronous reset on the 20th ON cycle, then a fresh divide.
    @(negedge clk); #1;
    bus_if.opdata1    = 32'd1000;
    bus_if.opdata2    = 32'd3;
    bus_if.signed_div = 1'b0;
    bus_if.start      = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    #1;
    chk("async_rst_ready", {63'h0, bus_if.ready}, 64'h0);
    chk("async_rst_result", bus_if.result, 64'h0);
    chk("async_rst_state", {62'h0, dbg_state}, 64'h0);
    #1;
    rst = 1'b0;
    do_div(32'd50, 32'd5, 1'b0, lat, res);
    chk("post_rst_lat", 64'(lat), 64'd34);
    chk("post_rst_res", res, 64'h00000000_0000000A);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
